// File: rtl/div_seq_if.sv
// Handshake bundle for div_seq: operand request channel and result channel.
// DIV_STATUS_EN adds the div_zero/div_ovf status flags to the result channel.
interface div_seq_if #(
    parameter int NW = 18,
    parameter int DW = 9
);
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
`ifdef DIV_STATUS_EN
    logic          div_zero;
    logic          div_ovf;
`endif

    modport master (
        output in_valid, dividend, divisor, out_ready,
`ifdef DIV_STATUS_EN
        input  div_zero, div_ovf,
`endif
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
`ifdef DIV_STATUS_EN
        output div_zero, div_ovf,
`endif
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/div_seq.sv
// Iterative signed restoring divider, one quotient bit per cycle, valid/ready both sides.
// Define DIV_STATUS_EN to add the div_zero/div_ovf status outputs.
module div_seq #(
    parameter int NW = 18,
    parameter int DW = 9
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(NW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [NW-1:0] q_acc;
    logic [DW:0]   rem;
    logic [DW:0]   dabs;
    logic          n_neg;
    logic          d_neg;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [NW-1:0] quot_r;
    logic [DW-1:0] rem_r;
`ifdef DIV_STATUS_EN
    logic          zero_r;
    logic          ovf_r;
`endif

    logic [NW-1:0] nabs_c;
    logic [DW:0]   dext_c;
    logic [DW:0]   dabs_c;
    logic [DW:0]   trial;
    logic          fits;

    // Dividend magnitude is read as unsigned, so -2^(NW-1) stays exact in NW bits.
    always_comb begin
        nabs_c = bus.dividend[NW-1] ? (NW'(0) - bus.dividend) : bus.dividend;
        dext_c = {bus.divisor[DW-1], bus.divisor};
        dabs_c = bus.divisor[DW-1] ? ((DW+1)'(0) - dext_c) : dext_c;
        trial  = {rem[DW-1:0], q_acc[NW-1]};
        fits   = rem[DW] | (trial >= dabs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_acc       <= '0;
            rem         <= '0;
            dabs        <= '0;
            n_neg       <= 1'b0;
            d_neg       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
`ifdef DIV_STATUS_EN
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        q_acc      <= nabs_c;
                        dabs       <= dabs_c;
                        n_neg      <= bus.dividend[NW-1];
                        d_neg      <= bus.divisor[DW-1];
                        rem        <= '0;
                        cnt        <= CW'(NW-1);
                        in_ready_r <= 1'b0;
`ifdef DIV_STATUS_EN
                        zero_r     <= 1'b0;
                        ovf_r      <= 1'b0;
`endif
                        state      <= (dabs_c == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    // q_acc shifts dividend bits out at the top and quotient bits in at the bottom.
                    q_acc <= {q_acc[NW-2:0], fits};
                    rem   <= fits ? (trial - dabs) : trial;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    if (dabs == '0) begin
                        quot_r <= '1;
                        rem_r  <= '0;
                    end else begin
                        quot_r <= (n_neg ^ d_neg) ? (NW'(0) - q_acc) : q_acc;
                        rem_r  <= n_neg ? (DW'(0) - rem[DW-1:0]) : rem[DW-1:0];
                    end
`ifdef DIV_STATUS_EN
                    zero_r <= (dabs == '0);
                    ovf_r  <= n_neg && d_neg && (dabs == (DW+1)'(1)) &&
                              (q_acc == (NW'(1) << (NW-1)));
`endif
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
`ifdef DIV_STATUS_EN
    assign bus.div_zero  = zero_r;
    assign bus.div_ovf   = ovf_r;
`endif
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results queued at drive time, popped on out_valid.
module tb_div_seq;
    localparam int NW = 18;
    localparam int DW = 9;

    typedef struct {
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          z;
        logic          o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    div_seq_if #(.NW(NW), .DW(DW)) bus ();

    div_seq #(.NW(NW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = '0;
            e.z = 1'b1;
        end else begin
            e.q = NW'(a / b);
            e.r = DW'(a % b);
            e.z = 1'b0;
        end
        e.o = (a == -(1 << (NW-1))) && (b == -1);
        return e;
    endfunction

    task automatic run_op(input int a, input int b, input int hold);
        exp_t e;
        int   n;
        int   lat;
        logic [NW-1:0] q_snap;
        logic [DW-1:0] r_snap;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_op", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = NW'(a);
        bus.divisor  = DW'(b);
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = NW'($urandom);
        bus.divisor  = DW'($urandom);
        check("ready_low_after_accept", 32'(bus.in_ready), 32'd0);
`ifdef DIV_STATUS_EN
        check("flags_clear_on_accept", {30'd0, bus.div_zero, bus.div_ovf}, 32'd0);
`endif
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), (b == 0) ? 32'd1 : 32'(NW + 1));
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("quotient", 32'(bus.quotient), 32'(e.q));
            check("remainder", 32'(bus.remainder), 32'(e.r));
`ifdef DIV_STATUS_EN
            check("div_zero", 32'(bus.div_zero), 32'(e.z));
            check("div_ovf", 32'(bus.div_ovf), 32'(e.o));
`endif
        end
        q_snap = bus.quotient;
        r_snap = bus.remainder;
        repeat (hold) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.dividend = NW'($urandom);
            bus.divisor  = DW'($urandom);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            check("stall_q", 32'(bus.quotient), 32'(q_snap));
            check("stall_r", 32'(bus.remainder), 32'(r_snap));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("retire_valid", 32'(bus.out_valid), 32'd0);
        check("retire_ready", 32'(bus.in_ready), 32'd1);
        check("retire_q_held", 32'(bus.quotient), 32'(q_snap));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);

        run_op(100, 7, 0);
        run_op(-100, 7, 0);
        run_op(100, -7, 0);
        run_op(-100, -7, 0);
        run_op(-131072, -1, 0);
        run_op(131071, -256, 0);
        run_op(5, 0, 0);
        run_op(0, 5, 0);
        run_op(-131072, 1, 0);
        run_op(-131072, -256, 0);
        run_op(1000, 3, 10);
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 262143)) - 131072;
            b = int'($urandom_range(0, 511)) - 256;
            run_op(a, b, int'($urandom_range(0, 2)));
        end

        // Abort an operation mid-CALC; its result must never appear.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = NW'(100);
        bus.divisor  = DW'(7);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_stale", 32'(bus.out_valid), 32'd0);
        run_op(9, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
